// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - multiplexed common-anode seven-segment display scanner
// Ports:
//   clock       system clock, rising edge
//   sys_rst_n   asynchronous reset, active-high (1 = reset)
//   enable      0 blanks every digit; scan counters keep running
//   lz_en       1 suppresses leading zeros (digit 0 never suppressed)
//   wr_en       load strobe for the wr_* shadow registers
//   wr_data     hex nibbles, digit i at [4i+3:4i], digit 0 rightmost
//   wr_dp       decimal point per digit, 1 = lit
//   wr_mask     1 = digit permanently dark
//   wr_blink    1 = digit blinks
//   control     digit select, active-low, at most one bit low
//   cube_data   segments {dp,g,f,e,d,c,b,a}, active-low
//   frame_done  one-cycle pulse after the last digit slot of a scan
module seg7_scan_ctrl #(
   parameter int DIGITS      = 8,
   parameter int CLK_DIV     = 10000,
   parameter int BLINK_TICKS = 2048
) (
   input  logic                  clock,
   input  logic                  sys_rst_n,
   input  logic                  enable,
   input  logic                  lz_en,
   input  logic                  wr_en,
   input  logic [4*DIGITS-1:0]   wr_data,
   input  logic [DIGITS-1:0]     wr_dp,
   input  logic [DIGITS-1:0]     wr_mask,
   input  logic [DIGITS-1:0]     wr_blink,
   output logic [DIGITS-1:0]     control,
   output logic [7:0]            cube_data,
   output logic                  frame_done
);

   localparam int PW = $clog2(CLK_DIV);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(CLK_DIV - 1);
   localparam logic [IW-1:0] I_LAST = IW'(DIGITS - 1);
   localparam logic [BW-1:0] B_LAST = BW'(BLINK_TICKS - 1);

   logic [PW-1:0]         pcnt;
   logic [IW-1:0]         idx;
   logic [BW-1:0]         bcnt;
   logic                  bph;
   logic [4*DIGITS-1:0]   data;
   logic [DIGITS-1:0]     dp;
   logic [DIGITS-1:0]     mask;
   logic [DIGITS-1:0]     blink;

   logic                  tick;
   logic [DIGITS-1:0]     hi_zero;
   logic                  zero_acc;
   logic [DIGITS-1:0]     sel_n;
   logic [3:0]            cur_nib;
   logic                  cur_dp;
   logic                  cur_mask;
   logic                  cur_blink;
   logic                  cur_sup;
   logic                  dark;

   function automatic logic [6:0] hex_seg(input logic [3:0] v);
      case (v)
         4'h0: hex_seg = 7'h3F;
         4'h1: hex_seg = 7'h06;
         4'h2: hex_seg = 7'h5B;
         4'h3: hex_seg = 7'h4F;
         4'h4: hex_seg = 7'h66;
         4'h5: hex_seg = 7'h6D;
         4'h6: hex_seg = 7'h7D;
         4'h7: hex_seg = 7'h07;
         4'h8: hex_seg = 7'h7F;
         4'h9: hex_seg = 7'h6F;
         4'hA: hex_seg = 7'h77;
         4'hB: hex_seg = 7'h7C;
         4'hC: hex_seg = 7'h39;
         4'hD: hex_seg = 7'h5E;
         4'hE: hex_seg = 7'h79;
         default: hex_seg = 7'h71;
      endcase
   endfunction

   assign tick = (pcnt == P_LAST);

   // hi_zero[i] = nibbles i..DIGITS-1 are all zero (scan from the left edge)
   always_comb begin
      zero_acc = 1'b1;
      hi_zero  = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zero_acc   = zero_acc & (data[4*i +: 4] == 4'h0);
         hi_zero[i] = zero_acc;
      end
   end

   // Mux out the shadow state of the digit currently being scanned
   always_comb begin
      cur_nib   = 4'h0;
      cur_dp    = 1'b0;
      cur_mask  = 1'b1;
      cur_blink = 1'b0;
      cur_sup   = 1'b0;
      sel_n     = '1;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx == IW'(i)) begin
            cur_nib   = data[4*i +: 4];
            cur_dp    = dp[i];
            cur_mask  = mask[i];
            cur_blink = blink[i];
            cur_sup   = (i > 0) && lz_en && hi_zero[i];
            sel_n[i]  = 1'b0;
         end
      end
      dark = !enable || cur_mask || (cur_blink && bph);
   end

   always_ff @(posedge clock or posedge sys_rst_n) begin
      if (sys_rst_n) begin
         pcnt       <= '0;
         idx        <= '0;
         bcnt       <= '0;
         bph        <= 1'b0;
         data       <= '0;
         dp         <= '0;
         mask       <= '1;
         blink      <= '0;
         control    <= '1;
         cube_data  <= 8'hFF;
         frame_done <= 1'b0;
      end else begin
         pcnt <= tick ? '0 : pcnt + 1'b1;
         if (tick) begin
            idx <= (idx == I_LAST) ? '0 : idx + 1'b1;
            if (bcnt == B_LAST) begin
               bcnt <= '0;
               bph  <= ~bph;
            end else begin
               bcnt <= bcnt + 1'b1;
            end
         end
         frame_done <= tick && (idx == I_LAST);
         if (wr_en) begin
            data  <= wr_data;
            dp    <= wr_dp;
            mask  <= wr_mask;
            blink <= wr_blink;
         end
         // Outputs are computed from pre-edge idx/shadow, so they lag by one clock
         control   <= dark ? '1 : sel_n;
         cube_data <= dark ? 8'hFF : ~{cur_dp, (cur_sup ? 7'h00 : hex_seg(cur_nib))};
      end
   end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - directed self-checking bench for seg7_scan_ctrl
module tb_seg7_scan_ctrl;

   logic        clock = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        enable = 1'b1;
   logic        lz_en = 1'b0;
   logic        wr_en = 1'b0;
   logic [15:0] wr_data = '0;
   logic [3:0]  wr_dp = '0;
   logic [3:0]  wr_mask = '0;
   logic [3:0]  wr_blink = '0;
   logic [3:0]  control;
   logic [7:0]  cube_data;
   logic        frame_done;

   int checks = 0;
   int failures = 0;
   int e = 0;   // rising edges since reset release

   seg7_scan_ctrl #(.DIGITS(4), .CLK_DIV(4), .BLINK_TICKS(8)) dut (
      .clock      (clock),
      .sys_rst_n  (sys_rst_n),
      .enable     (enable),
      .lz_en      (lz_en),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .wr_dp      (wr_dp),
      .wr_mask    (wr_mask),
      .wr_blink   (wr_blink),
      .control    (control),
      .cube_data  (cube_data),
      .frame_done (frame_done)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s e=%0d got=%h exp=%h", tag, e, got, exp);
      end
   endtask

   task automatic adv();
      @(negedge clock);
      e++;
   endtask

   task automatic do_write(input logic [15:0] d, input logic [3:0] p,
                           input logic [3:0] m, input logic [3:0] b);
      wr_data  = d;
      wr_dp    = p;
      wr_mask  = m;
      wr_blink = b;
      wr_en    = 1'b1;
      adv();
      wr_en    = 1'b0;
   endtask

   // Output at edge e shows digit ((e-1)/4)%4; blink phase toggles every 32 edges
   task automatic run_slots(input int n, input logic [31:0] cubes, input logic [3:0] dark,
                            input logic [3:0] blink, input string tag);
      int d;
      logic bph_m;
      logic off;
      logic [3:0] ec;
      logic [7:0] eq;
      for (int k = 0; k < n; k++) begin
         adv();
         d     = ((e - 1) / 4) % 4;
         bph_m = (((e - 1) / 32) % 2) == 1;
         off   = dark[d] | (blink[d] & bph_m);
         ec    = off ? 4'hF : (4'hF ^ (4'h1 << d));
         eq    = off ? 8'hFF : cubes[8*d +: 8];
         check_eq({tag, "_ctl"}, 32'(control), 32'(ec));
         check_eq({tag, "_seg"}, 32'(cube_data), 32'(eq));
         check_eq({tag, "_fd"}, 32'(frame_done), 32'((e % 16) == 0));
      end
   endtask

   initial begin
      #1 sys_rst_n = 1'b1;
      repeat (2) @(negedge clock);
      check_eq("rst_ctl", 32'(control), 32'hF);
      check_eq("rst_seg", 32'(cube_data), 32'hFF);
      check_eq("rst_fd", 32'(frame_done), 32'h0);
      sys_rst_n = 1'b0;
      e = 0;

      // 12AF: F,A,2,1 from digit 0 upward
      do_write(16'h12AF, 4'h0, 4'h0, 4'h0);
      check_eq("first_dark", 32'(control), 32'hF);
      run_slots(32, 32'hF9A4_888E, 4'h0, 4'h0, "scan");

      // Leading-zero suppression on 0050
      lz_en = 1'b1;
      do_write(16'h0050, 4'h0, 4'h0, 4'h0);
      run_slots(16, 32'hFFFF_92C0, 4'h0, 4'h0, "lz_on");
      lz_en = 1'b0;
      run_slots(16, 32'hC0C0_92C0, 4'h0, 4'h0, "lz_off");

      // Mask digit 2, dp on digit 0
      do_write(16'h8888, 4'b0001, 4'b0100, 4'h0);
      run_slots(16, 32'h80FF_8000, 4'b0100, 4'h0, "mask_dp");

      // Blink digit 0
      do_write(16'h8888, 4'h0, 4'h0, 4'b0001);
      run_slots(64, 32'h8080_8080, 4'h0, 4'b0001, "blink");

      // Asynchronous reset in the middle of the idx=2 slot
      while ((e % 16) != 9) adv();
      #2 sys_rst_n = 1'b1;
      #1;
      check_eq("arst_ctl", 32'(control), 32'hF);
      check_eq("arst_seg", 32'(cube_data), 32'hFF);
      check_eq("arst_fd", 32'(frame_done), 32'h0);
      @(negedge clock);
      sys_rst_n = 1'b0;
      e = 0;
      run_slots(8, 32'h0, 4'hF, 4'h0, "post_rst");
      do_write(16'h12AF, 4'h0, 4'h0, 4'h0);
      run_slots(8, 32'hF9A4_888E, 4'h0, 4'h0, "restart");

      // Write landing on a tick edge
      while ((e % 4) != 3) adv();
      do_write(16'h3333, 4'h0, 4'h0, 4'h0);
      check_eq("wrtick_old", 32'(cube_data), 32'h8E);
      run_slots(8, 32'hB0B0_B0B0, 4'h0, 4'h0, "wrtick");

      // enable=0 blanks, then comes back
      enable = 1'b0;
      run_slots(4, 32'h0, 4'hF, 4'h0, "en_off");
      enable = 1'b1;
      run_slots(4, 32'hB0B0_B0B0, 4'h0, 4'h0, "en_on");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
